adder_16_arbiter: RTL
=====================

ADDER_16_ARBITER -- requirements
Module: adder_16_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/sum width; only 16 is supported because the shared datapath is adder_16.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has operands pending.
REQ-005 Port: req0_a, req0_b  input  16 each  requester 0 operands.
REQ-006 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 Port: req1_valid, req1_a, req1_b, req1_ready  same directions/widths as requester 0  requester 1 equivalents.
REQ-008 Port: rsp_valid  output  1  result available.
REQ-009 Port: rsp_sum  output  16  a+b modulo 2^16.
REQ-010 Port: rsp_id  output  1  requester owning rsp_sum (0 or 1).
REQ-011 Port: rsp_ready  input  1  consumer accepts result.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-013 IDLE: grant computed combinationally; reqN_ready SHALL be 1 only for the granted requester, only in IDLE, and only if reqN_valid=1.
REQ-014 Arbitration: one valid -> grant it; both valid -> grant the requester not in last_grant; neither -> no grant, stay IDLE.
REQ-015 Acceptance edge (valid&ready): latch a, b and id into operand registers, update last_grant to id, go to EXEC.
REQ-016 EXEC: latched operands drive the adder; at the next edge sum SHALL register into rsp_sum, id into rsp_id, go to RESP.
REQ-017 RESP: rsp_valid=1; rsp_sum/rsp_id stable until rsp_valid&rsp_ready sampled, then go to IDLE.
REQ-018 Latency: rsp_valid rises exactly 2 cycles after the acceptance edge when no stall; minimum issue interval 3 cycles.
REQ-019 No new request SHALL be accepted in EXEC or RESP; both reqN_ready=0 there.
REQ-020 Arithmetic: carry out of bit 15 SHALL be discarded (0xFFFF+0x0001 -> 0x0000); no overflow flag.
REQ-021 Requester dropping valid before ready: no acceptance, no state change, no last_grant update.
REQ-022 rsp_ready held high while rsp_valid=0 SHALL have no effect.

Reset
REQ-023 On rst=1 asynchronously: state=IDLE, rsp_valid=0, rsp_sum=0, rsp_id=0, operand registers=0, last_grant=1 (requester 0 wins first tie).
REQ-024 Reset mid-EXEC or mid-RESP SHALL abort the operation; no response emitted after release.
REQ-025 reqN_ready SHALL be 0 while rst=1.

Structure
REQ-026 Shared package: FSM state encoding (IDLE=0, EXEC=1, RESP=2, 2 bits) and WIDTH default constant.
REQ-027 Exactly one sub-module: an adder_16 instance, fed only from operand registers (no combinational path from req inputs to rsp_sum).

Verification
REQ-028 req0 a=0xCB00 b=0x1995, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_sum=0xE495, rsp_id=0.
REQ-029 Both valid same cycle after reset, req0 0xCBF0+0x0001, req1 0xCB1F+0x1F95 -> req0 first (0xCBF1, id 0), then req1 (0xEAB4, id 1); grants alternate while both stay valid.
REQ-030 req1 a=0xFFFF b=0x0001 -> rsp_sum=0x0000, rsp_id=1.
REQ-031 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_sum held, both reqN_ready=0, new valids ignored until handshake.
REQ-032 rst asserted in EXEC with op 0x0000+0x1995 pending -> outputs zero immediately, no rsp_valid after release, next request served normally.

Source files
------------

// File: rtl/adder_16_arbiter_pkg.sv
// Shared types and constants for the two-requester 16-bit adder arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   WIDTH_DEFAULT - operand/sum width of the shared datapath
//   state_e       - control FSM encoding (IDLE=0, EXEC=1, RESP=2)
//   grant_t       - arbitration decision (valid + winning requester id)
//   arb_pick()    - two-way round-robin pick against the last grant
package adder_16_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } grant_t;

    // A lone requester always wins.
    // When both requesters are valid, the one that did not win last time is granted.
    function automatic grant_t arb_pick(input logic v0, input logic v1, input logic last_id);
        grant_t g;
        g.vld = 1'b0;
        g.id  = 1'b0;
        if (v0 && v1) begin
            g.vld = 1'b1;
            g.id  = ~last_id;
        end else if (v0) begin
            g.vld = 1'b1;
            g.id  = 1'b0;
        end else if (v1) begin
            g.vld = 1'b1;
            g.id  = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_16_arbiter_adder_16.sv
// 16-bit modulo adder used as the shared datapath of the arbiter.
// Latency: combinational.
// Backpressure: none. The carry out of bit 15 is discarded and no overflow is reported.
//
// Ports:
//   a, b - operands
//   sum  - (a + b) mod 2^16
module adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    // The add is evaluated in a 16-bit context, so the carry out of bit 15 is dropped.
    assign sum = a + b;

endmodule

// File: rtl/adder_16_arbiter.sv
// Arbitrates two operand requesters onto one shared 16-bit adder and returns a tagged sum.
// Latency: rsp_valid rises 2 cycles after the acceptance edge; a new request can issue at most every 3 cycles.
// Backpressure: rsp_ready=0 holds the response in RESP. No request is accepted until that response is consumed.
//
// Ports:
//   clk, rst                         - clock; asynchronous active-high reset
//   reqN_valid, reqN_a, reqN_b       - requester N operands (N = 0, 1)
//   reqN_ready                       - high only in IDLE, for the granted and valid requester
//   rsp_valid, rsp_sum, rsp_id       - registered result and the id of its owner
//   rsp_ready                        - consumer accepts the result
module adder_16_arbiter
    import adder_16_arbiter_pkg::*;
#(
    // The shared datapath is a fixed 16-bit adder, so only 16 is meaningful.
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,

    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_id,
    input  logic             rsp_ready
);

    state_e           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] op_a_q,       op_a_d;
    logic [WIDTH-1:0] op_b_q,       op_b_d;
    logic             op_id_q,      op_id_d;
    logic [WIDTH-1:0] rsp_sum_q,    rsp_sum_d;
    logic             rsp_id_q,     rsp_id_d;

    grant_t           grant;
    logic             accept;
    logic [WIDTH-1:0] add_sum;

    // ------------------------------------------------------------------
    // Grant. It is evaluated only in IDLE and is suppressed while rst is high.
    // A granted requester is valid by construction, so an active grant
    // means the request is accepted at the next edge.
    // ------------------------------------------------------------------
    always_comb begin
        grant.vld = 1'b0;
        grant.id  = 1'b0;
        if ((state_q == IDLE) && !rst) begin
            grant = arb_pick(req0_valid, req1_valid, last_grant_q);
        end
    end

    assign accept     = grant.vld;
    assign req0_ready = grant.vld && !grant.id;
    assign req1_ready = grant.vld &&  grant.id;

    // ------------------------------------------------------------------
    // Shared datapath. It is fed only from the operand registers, so
    // there is no combinational path from the request ports to rsp_sum.
    // ------------------------------------------------------------------
    adder_16 u_adder (
        .a   (op_a_q),
        .b   (op_b_q),
        .sum (add_sum)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath register updates.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d       = grant.id ? req1_a : req0_a;
                    op_b_d       = grant.id ? req1_b : req0_b;
                    op_id_d      = grant.id;
                    last_grant_d = grant.id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_sum_d = add_sum;
                rsp_id_d  = op_id_q;
                state_d   = RESP;
            end
            RESP: begin
                // The result stays on the outputs until the consumer takes it.
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule
